// File: rtl/jtd_ctrl_param.sv
// jtd_ctrl_param: two-road traffic-light controller with a BCD/7-segment phase countdown.
// Optional macro ALL_RED_EN inserts all-red clearance phases (S_AR1/S_AR2) after each yellow.
module jtd_ctrl_param #(
   parameter int TICK_DIV = 50000000,
   parameter int G1_TIME  = 25,
   parameter int G2_TIME  = 20,
   parameter int Y_TIME   = 5,
   parameter int AR_TIME  = 2,
   parameter int MAX_EXT  = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       sen1,
   input  logic       sen2,
   input  logic       ys,
   output logic       R1,
   output logic       G1,
   output logic       Y1,
   output logic       R2,
   output logic       G2,
   output logic       Y2,
   output logic [7:0] cnt_bcd,
   output logic [6:0] seg_tens,
   output logic [6:0] seg_ones
);

   localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

   localparam logic [6:0] G1_LOAD = 7'(G1_TIME);
   localparam logic [6:0] G2_LOAD = 7'(G2_TIME);
   localparam logic [6:0] Y_LOAD  = 7'(Y_TIME);
   localparam logic [6:0] EXT_MAX = 7'(MAX_EXT);

`ifdef ALL_RED_EN
   localparam bit AR_ON = 1'b1;
`else
   localparam bit AR_ON = 1'b0;
`endif

   // Duration loaded when a yellow ends: clearance time or the opposite green.
   localparam logic [6:0] Y1_NEXT_LOAD = AR_ON ? 7'(AR_TIME) : G2_LOAD;
   localparam logic [6:0] Y2_NEXT_LOAD = AR_ON ? 7'(AR_TIME) : G1_LOAD;

   typedef enum logic [2:0] {
      S_G1    = 3'd0,
      S_Y1    = 3'd1,
      S_G2    = 3'd2,
      S_Y2    = 3'd3,
      S_FLASH = 3'd4
`ifdef ALL_RED_EN
      ,
      S_AR1   = 3'd5,
      S_AR2   = 3'd6
`endif
   } state_t;

   state_t        state_q;
   logic [6:0]    cnt_q;
   logic [6:0]    ext_q;
   logic          blink_q;
   logic [PW-1:0] presc_q;
   logic [2:0]    meta_q;
   logic [2:0]    sync_q;

   logic tick;
   logic sen1_s;
   logic sen2_s;
   logic ys_s;
   logic ext1_ok;
   logic ext2_ok;

   assign tick    = (presc_q == PRESC_LAST);
   assign sen1_s  = sync_q[0];
   assign sen2_s  = sync_q[1];
   assign ys_s    = sync_q[2];
   assign ext1_ok = sen1_s && !sen2_s && (ext_q < EXT_MAX);
   assign ext2_ok = sen2_s && !sen1_s && (ext_q < EXT_MAX);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         presc_q <= '0;
      end else if (tick) begin
         presc_q <= '0;
      end else begin
         presc_q <= presc_q + PW'(1);
      end
   end

   // Two-flop synchronisers for {ys, sen2, sen1}.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta_q <= '0;
         sync_q <= '0;
      end else begin
         meta_q <= {ys, sen2, sen1};
         sync_q <= meta_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_G1;
         cnt_q   <= G1_LOAD;
         ext_q   <= '0;
         blink_q <= 1'b0;
      end else if (state_q == S_FLASH) begin
         if (!ys_s) begin
            state_q <= S_G1;
            cnt_q   <= G1_LOAD;
            ext_q   <= '0;
            blink_q <= 1'b0;
         end else if (tick) begin
            blink_q <= ~blink_q;
         end
      end else if (ys_s) begin
         // Flash request overrides any pending hand-over or extension.
         state_q <= S_FLASH;
         ext_q   <= '0;
         blink_q <= 1'b1;
      end else if (tick) begin
         if (cnt_q > 7'd1) begin
            cnt_q <= cnt_q - 7'd1;
         end else begin
            case (state_q)
               S_G1: begin
                  if (ext1_ok) begin
                     cnt_q <= G1_LOAD;
                     ext_q <= ext_q + 7'd1;
                  end else begin
                     state_q <= S_Y1;
                     cnt_q   <= Y_LOAD;
                     ext_q   <= '0;
                  end
               end
               S_Y1: begin
`ifdef ALL_RED_EN
                  state_q <= S_AR1;
`else
                  state_q <= S_G2;
`endif
                  cnt_q <= Y1_NEXT_LOAD;
                  ext_q <= '0;
               end
               S_G2: begin
                  if (ext2_ok) begin
                     cnt_q <= G2_LOAD;
                     ext_q <= ext_q + 7'd1;
                  end else begin
                     state_q <= S_Y2;
                     cnt_q   <= Y_LOAD;
                     ext_q   <= '0;
                  end
               end
               S_Y2: begin
`ifdef ALL_RED_EN
                  state_q <= S_AR2;
`else
                  state_q <= S_G1;
`endif
                  cnt_q <= Y2_NEXT_LOAD;
                  ext_q <= '0;
               end
`ifdef ALL_RED_EN
               S_AR1: begin
                  state_q <= S_G2;
                  cnt_q   <= G2_LOAD;
                  ext_q   <= '0;
               end
               S_AR2: begin
                  state_q <= S_G1;
                  cnt_q   <= G1_LOAD;
                  ext_q   <= '0;
               end
`endif
               default: begin
                  state_q <= S_G1;
                  cnt_q   <= G1_LOAD;
                  ext_q   <= '0;
               end
            endcase
         end
      end
   end

   always_comb begin
      R1 = 1'b0;
      G1 = 1'b0;
      Y1 = 1'b0;
      R2 = 1'b0;
      G2 = 1'b0;
      Y2 = 1'b0;
      case (state_q)
         S_G1: begin
            G1 = 1'b1;
            R2 = 1'b1;
         end
         S_Y1: begin
            Y1 = 1'b1;
            R2 = 1'b1;
         end
         S_G2: begin
            R1 = 1'b1;
            G2 = 1'b1;
         end
         S_Y2: begin
            R1 = 1'b1;
            Y2 = 1'b1;
         end
`ifdef ALL_RED_EN
         S_AR1, S_AR2: begin
            R1 = 1'b1;
            R2 = 1'b1;
         end
`endif
         S_FLASH: begin
            Y1 = blink_q;
            Y2 = blink_q;
         end
         default: begin
            R1 = 1'b0;
         end
      endcase
   end

   function automatic logic [6:0] seg7(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'h7E;
         4'd1:    s = 7'h30;
         4'd2:    s = 7'h6D;
         4'd3:    s = 7'h79;
         4'd4:    s = 7'h33;
         4'd5:    s = 7'h5B;
         4'd6:    s = 7'h5F;
         4'd7:    s = 7'h70;
         4'd8:    s = 7'h7F;
         4'd9:    s = 7'h7B;
         default: s = 7'h00;
      endcase
      return s;
   endfunction

   logic [3:0] tens_w;
   logic [3:0] ones_w;
   logic       flash_w;

   assign flash_w = (state_q == S_FLASH);

   // Binary-to-BCD for 0..99: pick the largest multiple of ten not above cnt.
   always_comb begin
      tens_w = 4'd0;
      for (int i = 1; i < 10; i++) begin
         if (cnt_q >= 7'(10 * i)) begin
            tens_w = 4'(i);
         end
      end
      ones_w = 4'(cnt_q - (7'(tens_w) * 7'd10));
   end

   always_comb begin
      cnt_bcd  = 8'h00;
      seg_tens = 7'h00;
      seg_ones = 7'h00;
      if (!flash_w) begin
         cnt_bcd  = {tens_w, ones_w};
         seg_ones = seg7(ones_w);
         if (tens_w != 4'd0) begin
            seg_tens = seg7(tens_w);
         end
      end
   end

endmodule

// File: tb/tb_jtd_ctrl_param.sv
// Directed, table-driven bench for jtd_ctrl_param (TICK_DIV=2, G1=5, G2=4, Y=2, AR=2, MAX_EXT=2).
// Build with +define+ALL_RED_EN to exercise the clearance phases.
module tb_jtd_ctrl_param;

   logic       clk;
   logic       rst;
   logic       sen1;
   logic       sen2;
   logic       ys;
   logic       R1, G1, Y1, R2, G2, Y2;
   logic [7:0] cnt_bcd;
   logic [6:0] seg_tens;
   logic [6:0] seg_ones;

   int checks;
   int errors;
   int cyc;
   string cur_test;

   logic in_s1, in_s2, in_ys;

   // Lamp vectors ordered {R1,Y1,G1,R2,Y2,G2}.
   localparam logic [5:0] L_G1R2 = 6'b001_100;
   localparam logic [5:0] L_Y1R2 = 6'b010_100;
   localparam logic [5:0] L_R1G2 = 6'b100_001;
   localparam logic [5:0] L_R1Y2 = 6'b100_010;
   localparam logic [5:0] L_RR   = 6'b100_100;
   localparam logic [5:0] L_FL   = 6'b010_010;
   localparam logic [5:0] L_OFF  = 6'b000_000;

   typedef struct {
      int         n;
      logic       s1;
      logic       s2;
      logic       ys;
      logic [5:0] lamps;
      logic [7:0] bcd;
      logic       blank;
   } vec_t;

   vec_t vq[$];

   jtd_ctrl_param #(
      .TICK_DIV(2),
      .G1_TIME (5),
      .G2_TIME (4),
      .Y_TIME  (2),
      .AR_TIME (2),
      .MAX_EXT (2)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .sen1    (sen1),
      .sen2    (sen2),
      .ys      (ys),
      .R1      (R1),
      .G1      (G1),
      .Y1      (Y1),
      .R2      (R2),
      .G2      (G2),
      .Y2      (Y2),
      .cnt_bcd (cnt_bcd),
      .seg_tens(seg_tens),
      .seg_ones(seg_ones)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
      $fatal(1);
   end

   function automatic logic [6:0] seg_exp(input logic [3:0] d);
      case (d)
         4'd0: return 7'b1111110;
         4'd1: return 7'b0110000;
         4'd2: return 7'b1101101;
         4'd3: return 7'b1111001;
         4'd4: return 7'b0110011;
         4'd5: return 7'b1011011;
         4'd6: return 7'b1011111;
         4'd7: return 7'b1110000;
         4'd8: return 7'b1111111;
         4'd9: return 7'b1111011;
         default: return 7'b0000000;
      endcase
   endfunction

   task automatic cmp(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s/%s cycle %0d: got %h expected %h", cur_test, name, cyc, act, exp);
      end
   endtask

   task automatic check_out(input logic [5:0] l, input logic [7:0] b, input logic blank);
      logic [6:0] exp_st;
      logic [6:0] exp_so;
      exp_so = blank ? 7'h00 : seg_exp(b[3:0]);
      exp_st = (blank || b[7:4] == 4'd0) ? 7'h00 : seg_exp(b[7:4]);
      cmp("lamps", {2'b00, R1, Y1, G1, R2, Y2, G2}, {2'b00, l});
      cmp("cnt_bcd", cnt_bcd, b);
      cmp("seg_ones", {1'b0, seg_ones}, {1'b0, exp_so});
      cmp("seg_tens", {1'b0, seg_tens}, {1'b0, exp_st});
   endtask

   task automatic next_cycle();
      @(negedge clk);
      #1;
      cyc++;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      sen1 = 1'b0;
      sen2 = 1'b0;
      ys = 1'b0;
      in_s1 = 1'b0;
      in_s2 = 1'b0;
      in_ys = 1'b0;
      @(negedge clk);
      #1;
      rst = 1'b0;
      cyc = 0;
   endtask

   task automatic add(input int n, input logic [5:0] l, input logic [7:0] b, input logic blank);
      vec_t v;
      v.n = n;
      v.s1 = in_s1;
      v.s2 = in_s2;
      v.ys = in_ys;
      v.lamps = l;
      v.bcd = b;
      v.blank = blank;
      vq.push_back(v);
   endtask

   // Each tick spans two clocks, so each countdown value is visible for two cycles.
   task automatic add_phase(input logic [5:0] l, input int dur);
      for (int d = dur; d >= 1; d--) add(2, l, 8'(d), 1'b0);
   endtask

   task automatic run_vecs();
      foreach (vq[i]) begin
         sen1 = vq[i].s1;
         sen2 = vq[i].s2;
         ys = vq[i].ys;
         for (int k = 0; k < vq[i].n; k++) begin
            check_out(vq[i].lamps, vq[i].bcd, vq[i].blank);
            next_cycle();
         end
      end
      vq.delete();
   endtask

   initial begin
      checks = 0;
      errors = 0;
      cyc = 0;
      rst = 1'b1;
      sen1 = 1'b0;
      sen2 = 1'b0;
      ys = 1'b0;
      in_s1 = 1'b0;
      in_s2 = 1'b0;
      in_ys = 1'b0;

      cur_test = "reset_hold";
      repeat (3) @(posedge clk);
      #1;
      check_out(L_G1R2, 8'h05, 1'b0);

      cur_test = "normal_cycle";
      do_reset();
      add_phase(L_G1R2, 5);
      add_phase(L_Y1R2, 2);
`ifdef ALL_RED_EN
      add_phase(L_RR, 2);
`endif
      add_phase(L_R1G2, 4);
      add_phase(L_R1Y2, 2);
`ifdef ALL_RED_EN
      add_phase(L_RR, 2);
`endif
      add(2, L_G1R2, 8'h05, 1'b0);
      add(2, L_G1R2, 8'h04, 1'b0);
      run_vecs();

      cur_test = "ext_g1";
      do_reset();
      in_s1 = 1'b1;
      add_phase(L_G1R2, 5);
      add_phase(L_G1R2, 5);
      add_phase(L_G1R2, 5);
      in_s1 = 1'b0;
      add_phase(L_Y1R2, 2);
      run_vecs();

      cur_test = "no_ext_both";
      do_reset();
      in_s1 = 1'b1;
      in_s2 = 1'b1;
      add_phase(L_G1R2, 5);
      add_phase(L_Y1R2, 2);
      run_vecs();

      cur_test = "ext_g2";
      do_reset();
      in_s2 = 1'b1;
      add_phase(L_G1R2, 5);
      add_phase(L_Y1R2, 2);
`ifdef ALL_RED_EN
      add_phase(L_RR, 2);
`endif
      add_phase(L_R1G2, 4);
      add_phase(L_R1G2, 4);
      add_phase(L_R1G2, 4);
      in_s2 = 1'b0;
      add(2, L_R1Y2, 8'h02, 1'b0);
      run_vecs();

      cur_test = "flash";
      do_reset();
      add_phase(L_G1R2, 5);
      add_phase(L_Y1R2, 2);
`ifdef ALL_RED_EN
      add_phase(L_RR, 2);
`endif
      add(2, L_R1G2, 8'h04, 1'b0);
      in_ys = 1'b1;
      add(2, L_R1G2, 8'h03, 1'b0);
      add(1, L_R1G2, 8'h02, 1'b0);
      add(1, L_FL, 8'h00, 1'b1);
      add(2, L_OFF, 8'h00, 1'b1);
      add(2, L_FL, 8'h00, 1'b1);
      add(2, L_OFF, 8'h00, 1'b1);
      in_ys = 1'b0;
      add(2, L_FL, 8'h00, 1'b1);
      add(1, L_OFF, 8'h00, 1'b1);
      add(1, L_G1R2, 8'h05, 1'b0);
      add(2, L_G1R2, 8'h04, 1'b0);
      run_vecs();

      cur_test = "async_reset";
      do_reset();
      add_phase(L_G1R2, 5);
      run_vecs();
      check_out(L_Y1R2, 8'h02, 1'b0);
      #2;
      rst = 1'b1;
      #1;
      check_out(L_G1R2, 8'h05, 1'b0);
      @(negedge clk);
      #1;
      check_out(L_G1R2, 8'h05, 1'b0);
      rst = 1'b0;
      cyc = 0;
      add_phase(L_G1R2, 5);
      add(2, L_Y1R2, 8'h02, 1'b0);
      run_vecs();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
